// File: rtl/igmp_rx_parser_if.sv
// igmp_rx_parser_if
//   Word-stream handshake carrying an IGMP message into the parser.
//   in_valid : source has a word on in_data/in_last
//   in_ready : parser accepts the word when in_valid & in_ready
//   in_data  : 32-bit message word, big-endian (byte0 in [31:24])
//   in_last  : marks the final word of a message
//   master   : producer side (drives valid/data/last)
//   slave    : parser side (drives ready)
interface igmp_rx_parser_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/igmp_rx_parser.sv
// igmp_rx_parser
//   Streaming IGMP receiver. Accepts a message of any length on the rx word
//   stream, checks the Internet checksum over the whole message, decodes
//   v1/v2/v3 headers and buffers up to MAX_SRC v3 source addresses. Decoded
//   fields only change on a valid pulse; a rejected message leaves them intact.
// Ports
//   clk, rst      : clock, asynchronous active-low reset
//   rx            : slave side of the message word stream
//   valid/invalid : one-cycle verdict pulse, one cycle after the last word
//   typea..source : decoded header fields of the last good message
//   member_query/member_report/leave_group : type flags of the last good message
//   src_ovf       : last good message carried more sources than MAX_SRC
//   src_rd_idx    : source buffer read index
//   sourceadd     : buffer[src_rd_idx], 0 beyond the stored count
module igmp_rx_parser #(
    parameter int unsigned MAX_SRC = 4,
    parameter int unsigned IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    igmp_rx_parser_if.slave    rx,
    output logic               valid,
    output logic               invalid,
    output logic [7:0]         typea,
    output logic [7:0]         mrc,
    output logic [15:0]        checksum,
    output logic [31:0]        groupadd,
    output logic [3:0]         resv,
    output logic               s,
    output logic [2:0]         qrv,
    output logic [7:0]         qqic,
    output logic [15:0]        source,
    output logic               member_query,
    output logic               member_report,
    output logic               leave_group,
    output logic               src_ovf,
    input  logic [IDX_W-1:0]   src_rd_idx,
    output logic [31:0]        sourceadd
);

    // Buffer is sized to a power of two so the index slice always fits;
    // only entries 0..MAX_SRC-1 are ever written.
    localparam int unsigned AW    = (MAX_SRC > 1) ? $clog2(MAX_SRC) : 1;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W1,
        S_V3HDR,
        S_SRC,
        S_DROP,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               rdy_q;
    logic [15:0]        acc_q;
    logic               err_q;

    // Shadow copy of the message being parsed
    logic [7:0]         sh_type_q;
    logic [7:0]         sh_mrc_q;
    logic [15:0]        sh_csum_q;
    logic [31:0]        sh_group_q;
    logic [3:0]         sh_resv_q;
    logic               sh_s_q;
    logic [2:0]         sh_qrv_q;
    logic [7:0]         sh_qqic_q;
    logic [15:0]        sh_nsrc_q;
    logic [31:0]        sh_buf_q [DEPTH];
    logic [IDX_W-1:0]   sh_cnt_q;
    logic [15:0]        seen_q;

    // Committed source buffer
    logic [31:0]        buf_q [DEPTH];
    logic [IDX_W-1:0]   cnt_q;

    logic               fire;
    logic [17:0]        sum3;
    logic [16:0]        fold1;
    logic [15:0]        acc_d;
    logic               type_known;
    logic               src_final;

    assign rx.in_ready = rdy_q;

    always_comb begin
        fire  = rx.in_valid & rdy_q;
        // acc + hi + lo fits in 18 bits; two folds bring it back to 16 with
        // end-around carry fully applied.
        sum3  = {2'b00, acc_q} + {2'b00, rx.in_data[31:16]} + {2'b00, rx.in_data[15:0]};
        fold1 = {1'b0, sum3[15:0]} + {15'b0, sum3[17:16]};
        acc_d = fold1[15:0] + {15'b0, fold1[16]};
        type_known = (sh_type_q == 8'h11) || (sh_type_q == 8'h12) ||
                     (sh_type_q == 8'h16) || (sh_type_q == 8'h17);
        src_final  = ({1'b0, seen_q} + 17'd1) == {1'b0, sh_nsrc_q};
    end

    always_comb begin
        sourceadd = '0;
        if (src_rd_idx < cnt_q) begin
            sourceadd = buf_q[src_rd_idx[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rdy_q         <= 1'b0;
            acc_q         <= '0;
            err_q         <= 1'b0;
            sh_type_q     <= '0;
            sh_mrc_q      <= '0;
            sh_csum_q     <= '0;
            sh_group_q    <= '0;
            sh_resv_q     <= '0;
            sh_s_q        <= 1'b0;
            sh_qrv_q      <= '0;
            sh_qqic_q     <= '0;
            sh_nsrc_q     <= '0;
            sh_cnt_q      <= '0;
            seen_q        <= '0;
            cnt_q         <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sh_buf_q[i] <= '0;
                buf_q[i]    <= '0;
            end
            valid         <= 1'b0;
            invalid       <= 1'b0;
            typea         <= '0;
            mrc           <= '0;
            checksum      <= '0;
            groupadd      <= '0;
            resv          <= '0;
            s             <= 1'b0;
            qrv           <= '0;
            qqic          <= '0;
            source        <= '0;
            member_query  <= 1'b0;
            member_report <= 1'b0;
            leave_group   <= 1'b0;
            src_ovf       <= 1'b0;
        end else begin
            valid   <= 1'b0;
            invalid <= 1'b0;
            rdy_q   <= 1'b1;
            if (fire) begin
                acc_q <= acc_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (fire) begin
                        sh_type_q <= rx.in_data[31:24];
                        sh_mrc_q  <= rx.in_data[23:16];
                        sh_csum_q <= rx.in_data[15:0];
                        sh_resv_q <= '0;
                        sh_s_q    <= 1'b0;
                        sh_qrv_q  <= '0;
                        sh_qqic_q <= '0;
                        sh_nsrc_q <= '0;
                        sh_cnt_q  <= '0;
                        seen_q    <= '0;
                        err_q     <= rx.in_last;
                        if (rx.in_last) begin
                            state_q <= S_DONE;
                            rdy_q   <= 1'b0;
                        end else begin
                            state_q <= S_W1;
                        end
                    end
                end

                S_W1: begin
                    if (fire) begin
                        sh_group_q <= rx.in_data;
                        if (rx.in_last) begin
                            state_q <= S_DONE;
                            rdy_q   <= 1'b0;
                        end else if (sh_type_q == 8'h11) begin
                            state_q <= S_V3HDR;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_DROP;
                        end
                    end
                end

                S_V3HDR: begin
                    if (fire) begin
                        sh_resv_q <= rx.in_data[31:28];
                        sh_s_q    <= rx.in_data[27];
                        sh_qrv_q  <= rx.in_data[26:24];
                        sh_qqic_q <= rx.in_data[23:16];
                        sh_nsrc_q <= rx.in_data[15:0];
                        if (rx.in_last) begin
                            err_q   <= (rx.in_data[15:0] != 16'd0);
                            state_q <= S_DONE;
                            rdy_q   <= 1'b0;
                        end else if (rx.in_data[15:0] == 16'd0) begin
                            // Words after a zero-source header make it too long
                            err_q   <= 1'b1;
                            state_q <= S_DROP;
                        end else begin
                            state_q <= S_SRC;
                        end
                    end
                end

                S_SRC: begin
                    if (fire) begin
                        if (seen_q < 16'(MAX_SRC)) begin
                            sh_buf_q[seen_q[AW-1:0]] <= rx.in_data;
                            sh_cnt_q                 <= sh_cnt_q + IDX_W'(1);
                        end
                        seen_q <= seen_q + 16'd1;
                        if (src_final) begin
                            if (rx.in_last) begin
                                state_q <= S_DONE;
                                rdy_q   <= 1'b0;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= S_DROP;
                            end
                        end else if (rx.in_last) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                            rdy_q   <= 1'b0;
                        end
                    end
                end

                S_DROP: begin
                    if (fire && rx.in_last) begin
                        state_q <= S_DONE;
                        rdy_q   <= 1'b0;
                    end
                end

                S_DONE: begin
                    acc_q   <= '0;
                    state_q <= S_IDLE;
                    if (!err_q && type_known && (acc_q == 16'hFFFF)) begin
                        valid         <= 1'b1;
                        typea         <= sh_type_q;
                        mrc           <= sh_mrc_q;
                        checksum      <= sh_csum_q;
                        groupadd      <= sh_group_q;
                        resv          <= sh_resv_q;
                        s             <= sh_s_q;
                        qrv           <= sh_qrv_q;
                        qqic          <= sh_qqic_q;
                        source        <= sh_nsrc_q;
                        member_query  <= (sh_type_q == 8'h11);
                        member_report <= (sh_type_q == 8'h12) || (sh_type_q == 8'h16);
                        leave_group   <= (sh_type_q == 8'h17);
                        src_ovf       <= (sh_nsrc_q > 16'(MAX_SRC));
                        cnt_q         <= sh_cnt_q;
                        for (int unsigned i = 0; i < DEPTH; i++) begin
                            buf_q[i] <= sh_buf_q[i];
                        end
                    end else begin
                        invalid <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
